// File: rtl/turret_sequencer.sv
// Turret fire sequencer: jogs or auto-aims the X/Y servos one angle code per
// PWM frame, settles, holds the trigger servo at FIRE_ANGLE, retracts it and
// reports completion with a one-cycle o_Done pulse.
// Optional feature macro: FIRE_COOLDOWN_EN adds a COOLDOWN lockout state after
// RETRACT that keeps o_Busy high for COOLDOWN_FRAMES frames.
module turret_sequencer #(
  parameter int unsigned SETTLE_FRAMES   = 5,
  parameter int unsigned FIRE_FRAMES     = 25,
  parameter logic [3:0]  FIRE_ANGLE      = 4'd8,
  parameter int unsigned COOLDOWN_FRAMES = 50
) (
  input  logic       i_Clk,
  input  logic       clr,
  input  logic       i_Frame_Tick,
  input  logic       i_Manual,
  input  logic [3:0] i_Jog,
  input  logic       i_Fire_Req,
  input  logic [3:0] i_X_Target,
  input  logic [3:0] i_Y_Target,
  output logic [3:0] o_X_Angle,
  output logic [3:0] o_Y_Angle,
  output logic [3:0] o_Fire_Angle,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam logic [3:0] CENTRE      = 4'd7;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);
  localparam logic [7:0] FIRE_LAST   = 8'(FIRE_FRAMES - 1);

  // Frame counts are held in an 8-bit counter, so each must lie in 1..255.
  if (SETTLE_FRAMES == 0 || SETTLE_FRAMES > 255 ||
      FIRE_FRAMES == 0 || FIRE_FRAMES > 255 ||
      COOLDOWN_FRAMES == 0 || COOLDOWN_FRAMES > 255) begin : g_param_check
    $error("turret_sequencer: frame counts must be in 1..255");
  end

`ifdef FIRE_COOLDOWN_EN
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);
  typedef enum logic [2:0] {IDLE, AIM, SETTLE, FIRE, RETRACT, COOLDOWN} state_t;
`else
  typedef enum logic [2:0] {IDLE, AIM, SETTLE, FIRE, RETRACT} state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic [3:0] x_q, y_q;
  logic [3:0] tx_q, ty_q;
  logic       done_q;
  logic       on_target;

  // Move one code toward the target, or stay if already there.
  function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
    if (cur < tgt)      return cur + 4'd1;
    else if (cur > tgt) return cur - 4'd1;
    else                return cur;
  endfunction

  // Saturating jog on one axis; requesting both directions cancels out.
  function automatic logic [3:0] jog_axis(input logic [3:0] cur, input logic dec, input logic inc);
    if (dec && !inc && cur != 4'd0)  return cur - 4'd1;
    if (inc && !dec && cur != 4'd15) return cur + 4'd1;
    return cur;
  endfunction

  assign on_target = (x_q == tx_q) && (y_q == ty_q);

  // Next-state decision; frame-counted states advance on the tick that completes their count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_Fire_Req) state_d = AIM;
      AIM:     if (on_target) state_d = SETTLE;
      SETTLE:  if (i_Frame_Tick && cnt_q == SETTLE_LAST) state_d = FIRE;
      FIRE:    if (i_Frame_Tick && cnt_q == FIRE_LAST) state_d = RETRACT;
`ifdef FIRE_COOLDOWN_EN
      RETRACT:  if (i_Frame_Tick) state_d = COOLDOWN;
      COOLDOWN: if (i_Frame_Tick && cnt_q == COOL_LAST) state_d = IDLE;
`else
      RETRACT:  if (i_Frame_Tick) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register, per-state frame counter (cleared on every state change) and done pulse.
  always_ff @(posedge i_Clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == IDLE) && (state_q != IDLE);
      if (state_d != state_q)  cnt_q <= 8'd0;
      else if (i_Frame_Tick)   cnt_q <= cnt_q + 8'd1;
    end
  end

  // Servo angle registers: jogged in IDLE, stepped toward the latched target in AIM, held elsewhere.
  always_ff @(posedge i_Clk or posedge clr) begin
    if (clr) begin
      x_q  <= CENTRE;
      y_q  <= CENTRE;
      tx_q <= 4'd0;
      ty_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Fire_Req) begin
            tx_q <= i_Manual ? x_q : i_X_Target;
            ty_q <= i_Manual ? y_q : i_Y_Target;
          end else if (i_Manual && i_Frame_Tick) begin
            x_q <= jog_axis(x_q, i_Jog[0], i_Jog[1]);
            y_q <= jog_axis(y_q, i_Jog[3], i_Jog[2]);
          end
        end
        AIM: begin
          if (i_Frame_Tick) begin
            x_q <= step_toward(x_q, tx_q);
            y_q <= step_toward(y_q, ty_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_X_Angle    = x_q;
  assign o_Y_Angle    = y_q;
  assign o_Fire_Angle = (state_q == FIRE) ? FIRE_ANGLE : 4'd0;
  assign o_Busy       = (state_q != IDLE);
  assign o_Done       = done_q;

endmodule
